// File: rtl/fwd_source_tracker.sv
// fwd_source_tracker
//   Producer side of the decode-stage forwarding interface. Holds one entry
//   (valid, writes-GPR, destination, ready, data) per post-decode stage and
//   shifts them one stage per clock. Entry 0 is the youngest. Answers decode's
//   three source queries with per-stage match-and-ready flags, the stored
//   values and a hazard stall. The oldest entry retires into the GPR write port.
//
// Ports
//   clk, rstn        clock, asynchronous active-low reset
//   ins_valid/wr/dst instruction accepted by decode this cycle
//   q_d, q_s, q_t    source indices of the instruction currently in decode
//   res_we, res_val  per-stage result strobe and value
//   flush            kill all but the FLUSH_KEEP oldest entries, and the new one
//   fwd_sig_from[i]  {d,s,t} flags: stage i matches that source and is ready
//   fwd_val_from[i]  data held in stage i (valid or not)
//   stall_req        youngest match for some source is not ready yet
//   gpr_we/wa/wd     registered retire write, one-cycle strobe
//   err              sticky: a tracked entry retired without a result

// One pipeline stage: entry register, result capture and source match.
module fwd_source_tracker_stage #(
    parameter int IDX_W   = 5,
    parameter int DATA_W  = 32,
    parameter int RIP_IDX = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              in_v,
    input  logic              in_wr,
    input  logic [IDX_W-1:0]  in_dst,
    input  logic              in_rdy,
    input  logic [DATA_W-1:0] in_data,
    input  logic              res_we,
    input  logic [DATA_W-1:0] res_val,
    input  logic              kill,
    input  logic [IDX_W-1:0]  q_d,
    input  logic [IDX_W-1:0]  q_s,
    input  logic [IDX_W-1:0]  q_t,
    output logic              rdy,
    output logic [DATA_W-1:0] data,
    output logic [2:0]        hit,
    output logic              nx_v,
    output logic              nx_wr,
    output logic [IDX_W-1:0]  nx_dst,
    output logic              nx_rdy,
    output logic [DATA_W-1:0] nx_data
);
    logic             v;
    logic             wr;
    logic [IDX_W-1:0] dst;
    logic             cap;
    logic             trk;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            v    <= 1'b0;
            wr   <= 1'b0;
            dst  <= '0;
            rdy  <= 1'b0;
            data <= '0;
        end else begin
            v    <= in_v;
            wr   <= in_wr;
            dst  <= in_dst;
            rdy  <= in_rdy;
            data <= in_data;
        end
    end

    // A result only lands on a live entry; a repeat strobe just overwrites.
    assign cap     = res_we & v;
    assign nx_v    = v & ~kill;
    assign nx_wr   = wr;
    assign nx_dst  = dst;
    assign nx_rdy  = rdy | cap;
    assign nx_data = cap ? res_val : data;

    // RIP is a pseudo-register: it never forwards and never retires.
    assign trk = v & wr & (dst != IDX_W'(RIP_IDX));
    assign hit = {trk & (dst == q_d), trk & (dst == q_s), trk & (dst == q_t)};
endmodule

module fwd_source_tracker #(
    parameter int POST_DEC_LD = 3,
    parameter int IDX_W       = 5,
    parameter int DATA_W      = 32,
    parameter int RIP_IDX     = 16,
    parameter int FLUSH_KEEP  = 1
) (
    input  logic                               clk,
    input  logic                               rstn,
    input  logic                               ins_valid,
    input  logic                               ins_wr,
    input  logic [IDX_W-1:0]                   ins_dst,
    input  logic [IDX_W-1:0]                   q_d,
    input  logic [IDX_W-1:0]                   q_s,
    input  logic [IDX_W-1:0]                   q_t,
    input  logic [POST_DEC_LD-1:0]             res_we,
    input  logic [POST_DEC_LD-1:0][DATA_W-1:0] res_val,
    input  logic                               flush,
    output logic [POST_DEC_LD-1:0][2:0]        fwd_sig_from,
    output logic [POST_DEC_LD-1:0][DATA_W-1:0] fwd_val_from,
    output logic                               stall_req,
    output logic                               gpr_we,
    output logic [IDX_W-1:0]                   gpr_wa,
    output logic [DATA_W-1:0]                  gpr_wd,
    output logic                               err
);
    localparam int L = POST_DEC_LD - 1;

    logic [L:0]             rdy, nx_v, nx_wr, nx_rdy, kill;
    logic [L:0][IDX_W-1:0]  nx_dst;
    logic [L:0][DATA_W-1:0] data, nx_data;
    logic [L:0][2:0]        hit;
    logic                   accept;
    logic [2:0]             found, young_rdy;
    logic                   ret_trk;

    // A stalled or flushed decode inserts a bubble.
    assign accept = ins_valid & ~stall_req & ~flush;

    for (genvar i = 0; i <= L; i++) begin : g_stage
        logic              in_v, in_wr, in_rdy;
        logic [IDX_W-1:0]  in_dst;
        logic [DATA_W-1:0] in_data;

        if (i == 0) begin : g_head
            assign in_v    = accept;
            assign in_wr   = ins_wr;
            assign in_dst  = ins_dst;
            assign in_rdy  = 1'b0;
            assign in_data = '0;
        end else begin : g_body
            assign in_v    = nx_v[i-1];
            assign in_wr   = nx_wr[i-1];
            assign in_dst  = nx_dst[i-1];
            assign in_rdy  = nx_rdy[i-1];
            assign in_data = nx_data[i-1];
        end

        if (i <= L - FLUSH_KEEP) begin : g_kill
            assign kill[i] = flush;
        end else begin : g_keep
            assign kill[i] = 1'b0;
        end

        fwd_source_tracker_stage #(
            .IDX_W  (IDX_W),
            .DATA_W (DATA_W),
            .RIP_IDX(RIP_IDX)
        ) u_stage (
            .clk    (clk),
            .rstn   (rstn),
            .in_v   (in_v),
            .in_wr  (in_wr),
            .in_dst (in_dst),
            .in_rdy (in_rdy),
            .in_data(in_data),
            .res_we (res_we[i]),
            .res_val(res_val[i]),
            .kill   (kill[i]),
            .q_d    (q_d),
            .q_s    (q_s),
            .q_t    (q_t),
            .rdy    (rdy[i]),
            .data   (data[i]),
            .hit    (hit[i]),
            .nx_v   (nx_v[i]),
            .nx_wr  (nx_wr[i]),
            .nx_dst (nx_dst[i]),
            .nx_rdy (nx_rdy[i]),
            .nx_data(nx_data[i])
        );

        assign fwd_sig_from[i] = hit[i] & {3{rdy[i]}};
        assign fwd_val_from[i] = data[i];
    end

    // Only the youngest match per source matters: decode takes it, so an
    // older not-ready match behind a ready younger one is harmless.
    always_comb begin
        found     = '0;
        young_rdy = '0;
        for (int i = L; i >= 0; i--) begin
            for (int x = 0; x < 3; x++) begin
                if (hit[i][x]) begin
                    found[x]     = 1'b1;
                    young_rdy[x] = rdy[i];
                end
            end
        end
        stall_req = |(found & ~young_rdy);
    end

    // Retire looks at the oldest entry after this cycle's capture and flush.
    assign ret_trk = nx_v[L] & nx_wr[L] & (nx_dst[L] != IDX_W'(RIP_IDX));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            gpr_we <= 1'b0;
            gpr_wa <= '0;
            gpr_wd <= '0;
            err    <= 1'b0;
        end else begin
            gpr_we <= ret_trk & nx_rdy[L];
            if (ret_trk & nx_rdy[L]) begin
                gpr_wa <= nx_dst[L];
                gpr_wd <= nx_data[L];
            end
            if (ret_trk & ~nx_rdy[L])
                err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_fwd_source_tracker.sv
module tb_fwd_source_tracker;
    localparam int P   = 3;
    localparam int IW  = 5;
    localparam int DW  = 32;
    localparam int RIP = 16;
    localparam int FK  = 1;

    logic                clk = 1'b0;
    logic                rstn = 1'b0;
    logic                ins_valid, ins_wr, flush;
    logic [IW-1:0]       ins_dst, q_d, q_s, q_t;
    logic [P-1:0]        res_we;
    logic [P-1:0][DW-1:0] res_val;
    logic [P-1:0][2:0]   fwd_sig_from;
    logic [P-1:0][DW-1:0] fwd_val_from;
    logic                stall_req, gpr_we, err;
    logic [IW-1:0]       gpr_wa;
    logic [DW-1:0]       gpr_wd;

    fwd_source_tracker #(
        .POST_DEC_LD(P), .IDX_W(IW), .DATA_W(DW), .RIP_IDX(RIP), .FLUSH_KEEP(FK)
    ) dut (
        .clk(clk), .rstn(rstn), .ins_valid(ins_valid), .ins_wr(ins_wr),
        .ins_dst(ins_dst), .q_d(q_d), .q_s(q_s), .q_t(q_t), .res_we(res_we),
        .res_val(res_val), .flush(flush), .fwd_sig_from(fwd_sig_from),
        .fwd_val_from(fwd_val_from), .stall_req(stall_req), .gpr_we(gpr_we),
        .gpr_wa(gpr_wa), .gpr_wd(gpr_wd), .err(err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // ---------------- reference model: in-flight instructions by age -------
    typedef struct {
        bit          v;
        bit          wr;
        logic [4:0]  dst;
        bit          rdy;
        logic [31:0] data;
    } rec_t;

    rec_t        m[$];   // m[k] = instruction accepted k+1 cycles ago
    rec_t        mn[$];
    bit          e_we, e_err, n_we, n_err;
    logic [4:0]  e_wa, n_wa;
    logic [31:0] e_wd, n_wd;

    function automatic bit tracked(rec_t r);
        return r.v && r.wr && (r.dst != 5'(RIP));
    endfunction

    function automatic void model_reset();
        rec_t z;
        z = '{v:0, wr:0, dst:0, rdy:0, data:0};
        m.delete();
        for (int k = 0; k < P; k++) m.push_back(z);
        e_we = 0; e_err = 0; e_wa = 0; e_wd = 0;
    endfunction

    function automatic logic [2:0] exp_sig(int k);
        logic [2:0] s;
        s = 3'b000;
        if (tracked(m[k]) && m[k].rdy) begin
            s[2] = (m[k].dst == q_d);
            s[1] = (m[k].dst == q_s);
            s[0] = (m[k].dst == q_t);
        end
        return s;
    endfunction

    // For each source the youngest in-flight writer decides: waiting -> stall.
    function automatic bit exp_stall();
        logic [4:0] qs[3];
        bit st;
        qs[0] = q_d; qs[1] = q_s; qs[2] = q_t;
        st = 0;
        for (int x = 0; x < 3; x++) begin
            for (int k = 0; k < P; k++) begin
                if (tracked(m[k]) && m[k].dst == qs[x]) begin
                    if (!m[k].rdy) st = 1;
                    break;
                end
            end
        end
        return st;
    endfunction

    function automatic void model_next();
        rec_t t[$];
        rec_t old, nw;
        bit acc;
        t = m;
        acc = ins_valid && !exp_stall() && !flush;
        for (int k = 0; k < P; k++)
            if (res_we[k] && t[k].v) begin
                t[k].rdy  = 1;
                t[k].data = res_val[k];
            end
        if (flush)
            for (int k = 0; k <= P - 1 - FK; k++) t[k].v = 0;
        old = t.pop_back();
        n_we = 0; n_err = e_err; n_wa = e_wa; n_wd = e_wd;
        if (tracked(old)) begin
            if (old.rdy) begin
                n_we = 1; n_wa = old.dst; n_wd = old.data;
            end else begin
                n_err = 1;
            end
        end
        nw = '{v:acc, wr:ins_wr, dst:ins_dst, rdy:0, data:0};
        t.push_front(nw);
        mn = t;
    endfunction

    // ---------------- compare process: every cycle, mid-cycle -------------
    initial begin
        model_reset();
        forever begin
            @(negedge clk); #1;
            if (!rstn) model_reset();
            for (int k = 0; k < P; k++) begin
                chk($sformatf("sig%0d", k), 64'(fwd_sig_from[k]), 64'(exp_sig(k)));
                chk($sformatf("val%0d", k), 64'(fwd_val_from[k]), 64'(m[k].data));
            end
            chk("stall", 64'(stall_req), 64'(exp_stall()));
            chk("gpr_we", 64'(gpr_we), 64'(e_we));
            chk("gpr_wa", 64'(gpr_wa), 64'(e_wa));
            chk("gpr_wd", 64'(gpr_wd), 64'(e_wd));
            chk("err", 64'(err), 64'(e_err));
            model_next();
            @(posedge clk);
            if (!rstn) model_reset();
            else begin
                m = mn; e_we = n_we; e_err = n_err; e_wa = n_wa; e_wd = n_wd;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle();
        ins_valid = 0; ins_wr = 0; ins_dst = 0;
        q_d = 0; q_s = 0; q_t = 0;
        res_we = '0; res_val = '0; flush = 0;
    endtask

    task automatic nxt();            // advance to the next cycle's drive point
        @(posedge clk); #1;
        idle();
    endtask

    task automatic mid();            // literal-check point, after settling
        @(negedge clk); #2;
    endtask

    task automatic acc(input logic [4:0] d);
        ins_valid = 1; ins_wr = 1; ins_dst = d;
    endtask

    function automatic logic [4:0] pick();
        case ($urandom % 5)
            0: return 5'd2;
            1: return 5'd3;
            2: return 5'd5;
            3: return 5'(RIP);
            default: return 5'($urandom_range(0, 31));
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        idle();
        rstn = 0;
        #1;
        chk("rst_stall", 64'(stall_req), 0);
        chk("rst_we", 64'(gpr_we), 0);
        chk("rst_err", 64'(err), 0);
        repeat (2) @(posedge clk);
        #1 rstn = 1;

        // Basic forward
        acc(3); nxt();
        res_we[0] = 1; res_val[0] = 32'h1234; nxt();
        q_s = 3; mid();
        chk("bf_sig1", 64'(fwd_sig_from[1]), 64'b010);
        chk("bf_val1", 64'(fwd_val_from[1]), 64'h1234);
        chk("bf_stall", 64'(stall_req), 0);
        nxt(); nxt(); mid();
        chk("bf_we", 64'(gpr_we), 1);
        chk("bf_wa", 64'(gpr_wa), 3);
        chk("bf_wd", 64'(gpr_wd), 64'h1234);
        nxt();

        // Load-use
        acc(5); nxt();
        q_d = 5; acc(7); mid();
        chk("lu_stall1", 64'(stall_req), 1);
        nxt();
        q_d = 5; acc(7); res_we[1] = 1; res_val[1] = 32'h55; mid();
        chk("lu_stall2", 64'(stall_req), 1);
        nxt();
        q_d = 5; q_s = 7; mid();
        chk("lu_clear", 64'(stall_req), 0);
        chk("lu_sig2", 64'(fwd_sig_from[2]), 64'b100);
        chk("lu_sig1", 64'(fwd_sig_from[1]), 64'b000);
        repeat (4) nxt();

        // Priority
        acc(2); nxt();
        acc(2); res_we[0] = 1; res_val[0] = 32'hA; nxt();
        q_t = 2; res_we[0] = 1; res_val[0] = 32'hB; mid();
        chk("pr_stall", 64'(stall_req), 1);
        chk("pr_sig1", 64'(fwd_sig_from[1]), 64'b001);
        nxt();
        q_t = 2; mid();
        chk("pr_stall0", 64'(stall_req), 0);
        chk("pr_sig1b", 64'(fwd_sig_from[1]), 64'b001);
        chk("pr_sig2b", 64'(fwd_sig_from[2]), 64'b001);
        chk("pr_val1", 64'(fwd_val_from[1]), 64'hB);
        nxt(); mid();
        chk("pr_wd_a", 64'(gpr_wd), 64'hA);
        nxt(); mid();
        chk("pr_wd_b", 64'(gpr_wd), 64'hB);
        repeat (2) nxt();

        // RIP never matches or retires
        acc(5'(RIP)); nxt();
        q_d = 5'(RIP); res_we[0] = 1; res_val[0] = 32'h16; mid();
        chk("rip_stall", 64'(stall_req), 0);
        nxt();
        q_d = 5'(RIP); mid();
        chk("rip_sig1", 64'(fwd_sig_from[1]), 0);
        for (int k = 0; k < 3; k++) begin
            nxt(); mid();
            chk("rip_we", 64'(gpr_we), 0);
        end
        nxt();

        // Flush with three entries: only the oldest retires
        acc(3); nxt();
        acc(4); res_we[0] = 1; res_val[0] = 32'h33; nxt();
        acc(5); res_we[0] = 1; res_val[0] = 32'h44; nxt();
        acc(6); res_we[0] = 1; res_val[0] = 32'h55; flush = 1; nxt();
        mid();
        chk("fl_we", 64'(gpr_we), 1);
        chk("fl_wa", 64'(gpr_wa), 3);
        chk("fl_wd", 64'(gpr_wd), 64'h33);
        for (int k = 0; k < 3; k++) begin
            nxt(); mid();
            chk("fl_no_we", 64'(gpr_we), 0);
        end
        nxt();

        // Error: tracked entry retires without a result
        acc(9); nxt();
        repeat (3) nxt();
        mid();
        chk("er_we", 64'(gpr_we), 0);
        chk("er_err", 64'(err), 1);
        nxt(); nxt(); mid();
        chk("er_hold", 64'(err), 1);
        nxt();

        // Reset mid-stream with three valid entries
        acc(10); nxt();
        acc(11); res_we[0] = 1; res_val[0] = 32'h1010; nxt();
        acc(12); res_we[0] = 1; res_val[0] = 32'h1111; nxt();
        q_d = 10; q_t = 12; #1;
        chk("rs_pre_stall", 64'(stall_req), 1);
        chk("rs_pre_sig2", 64'(fwd_sig_from[2]), 64'b100);
        rstn = 0; #1;
        chk("rs_stall", 64'(stall_req), 0);
        chk("rs_err", 64'(err), 0);
        chk("rs_we", 64'(gpr_we), 0);
        for (int k = 0; k < P; k++) begin
            chk("rs_sig", 64'(fwd_sig_from[k]), 0);
            chk("rs_val", 64'(fwd_val_from[k]), 0);
        end
        @(posedge clk); @(posedge clk); #1;
        rstn = 1; idle();
        for (int k = 0; k < 5; k++) begin
            mid();
            chk("rs_no_we", 64'(gpr_we), 0);
            nxt();
        end

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            ins_valid = ($urandom % 4) != 0;
            ins_wr    = ($urandom % 4) != 0;
            ins_dst   = pick();
            q_d = pick(); q_s = pick(); q_t = pick();
            res_we    = P'($urandom);
            for (int k = 0; k < P; k++) res_val[k] = $urandom;
            flush     = ($urandom % 32) == 0;
            @(posedge clk); #1;
        end
        idle();
        repeat (2) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
